mult16_sequencer: RTL

// Sequences the existing single 8x8 unsigned lookup Multiplier to form wide unsigned products.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/multiplier.sv | 19 +
 rtl/mult16_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module : mult_pkg
// Brief  : Shared constants, FSM state encoding and limb-counter sizing for
//          the wide-product sequencer built around one 8x8 multiplier.
// Rev    : 1.0  initial release
// ============================================================================
package mult_pkg;

    localparam int LIMB_W = 8;
    localparam int PP_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a limb index counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module : multiplier
// Brief  : Combinational 8x8 unsigned multiplier producing a 16-bit product.
// Rev    : 1.0  initial release
// ============================================================================
module multiplier
    import mult_pkg::*;
(
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    output logic [PP_W-1:0]   p
);

    // Both operands widened first so the product keeps all 16 bits.
    assign p = PP_W'(a) * PP_W'(b);

endmodule
`default_nettype wire

// File: rtl/mult16_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mult16_sequencer
// Brief  : Forms an OW x OW unsigned product by issuing one 8x8 partial
//          product per cycle to a shared multiplier and shift-accumulating.
//          Valid/ready operand input, valid/ready product output.
// Rev    : 1.0  initial release
// ============================================================================
module mult16_sequencer
    import mult_pkg::*;
#(
    parameter int N_LIMBS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LIMB_W*N_LIMBS-1:0]  in_a,
    input  logic [LIMB_W*N_LIMBS-1:0]  in_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*LIMB_W*N_LIMBS-1:0] out_p,
    output logic                       busy
);

    localparam int OW = LIMB_W * N_LIMBS;
    localparam int PW = 2 * OW;
    localparam int IW = cnt_w(N_LIMBS);
    localparam logic [IW-1:0] LAST = IW'(N_LIMBS - 1);

    state_t          state;
    logic [OW-1:0]   a_reg;
    logic [OW-1:0]   b_reg;
    logic [PW-1:0]   acc;
    logic [IW-1:0]   i;
    logic [IW-1:0]   j;

    logic [LIMB_W-1:0] mul_a;
    logic [LIMB_W-1:0] mul_b;
    logic [PP_W-1:0]   pp;
    logic [PW-1:0]     pp_shift;
    logic              accept;

    // Select limb i of A and limb j of B for the current partial product.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int k = 0; k < N_LIMBS; k++) begin
            if (i == IW'(k)) mul_a = a_reg[k*LIMB_W +: LIMB_W];
            if (j == IW'(k)) mul_b = b_reg[k*LIMB_W +: LIMB_W];
        end
    end

    multiplier u_multiplier (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    // Partial product aligned to limb weight i+j; the sum is at most
    // 2*N_LIMBS-2 limbs, so the shift always stays within the accumulator.
    assign pp_shift = PW'(pp) << (LIMB_W * (int'(i) + int'(j)));

    // DONE hands the result off and may accept the next pair in the same cycle.
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_p     = acc;
    assign accept    = in_valid && in_ready;

    // Sequencer: operand capture, inner-j/outer-i limb walk, accumulate, hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc <= acc + pp_shift;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            i     <= '0;
                            state <= ST_DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            a_reg <= in_a;
                            b_reg <= in_b;
                            acc   <= '0;
                            i     <= '0;
                            j     <= '0;
                            state <= ST_MUL;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
